// File: rtl/i2s_rx_frontend_pkg.sv
// Shared constants and FSM encoding for the I2S / left-justified receive front end.
package i2s_rx_frontend_pkg;

    localparam int unsigned PCM_DATA_W   = 24;
    localparam int unsigned I2S_MAX_SLOT = 32;
    localparam int unsigned I2S_SYNC_STG = 2;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_DELAY,
        ST_SHIFT,
        ST_HOLD
    } rx_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-flop synchronizer for the serial pins; pin 0 is the bit clock and also gets
// a rising-edge detect in the system clock domain.
module i2s_pin_sync #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-2:0] sync_o,
    output logic             clk_rise_c
);

    logic [SYNC_STG-1:0][WIDTH-1:0] stg_q, stg_d;
    logic                           prev_q, prev_d;

    always_comb begin
        stg_d  = {stg_q[SYNC_STG-2:0], pins};
        prev_d = stg_q[SYNC_STG-1][0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            stg_q  <= stg_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o     = stg_q[SYNC_STG-1][WIDTH-1:1];
    assign clk_rise_c = stg_q[SYNC_STG-1][0] & ~prev_q;

endmodule

// File: rtl/i2s_rx_frontend.sv
// Oversampled I2S / left-justified receiver producing one stereo sample pulse per frame.
module i2s_rx_frontend
    import i2s_rx_frontend_pkg::*;
#(
    parameter int unsigned DATA_W   = PCM_DATA_W,
    parameter int unsigned MAX_SLOT = I2S_MAX_SLOT,
    parameter int unsigned SYNC_STG = I2S_SYNC_STG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fmt_sel,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdata,
    input  logic              clear_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              frame_err,
    output logic              locked
);

    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned IDX_W  = $clog2(DATA_W);
    localparam int unsigned SLOT_W = $clog2(MAX_SLOT + 1);

    rx_state_e         state_q, state_d;
    logic              fmt_q, fmt_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic              ch_q, ch_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] l_hold_q, l_hold_d;
    logic              have_l_q, have_l_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_l_q, out_l_d;
    logic [DATA_W-1:0] out_r_q, out_r_d;
    logic              frame_err_q, frame_err_d;
    logic              locked_q, locked_d;

    logic              bclk_rise;
    logic [1:0]        pin_sync;
    logic              lrck_s, sdata_s, lrck_edge;
    logic              start_slot, start_fmt, store, err_set;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  bit_idx;

    i2s_pin_sync #(
        .WIDTH    (3),
        .SYNC_STG (SYNC_STG)
    ) u_pin_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pins       ({i2s_sdata, i2s_lrck, i2s_bclk}),
        .sync_o     (pin_sync),
        .clk_rise_c (bclk_rise)
    );

    assign lrck_s  = pin_sync[0];
    assign sdata_s = pin_sync[1];

    always_comb begin
        state_d     = state_q;
        fmt_d       = fmt_q;
        lrck_prev_d = lrck_prev_q;
        ch_d        = ch_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shift_d     = shift_q;
        l_hold_d    = l_hold_q;
        have_l_d    = have_l_q;
        out_valid_d = 1'b0;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        locked_d    = locked_q;
        start_slot  = 1'b0;
        start_fmt   = fmt_q;
        store       = 1'b0;
        word        = shift_q;
        err_set     = 1'b0;
        bit_idx     = IDX_W'(DATA_W - 1) - IDX_W'(bit_cnt_q);
        lrck_edge   = bclk_rise && (lrck_s != lrck_prev_q);

        if (bclk_rise) begin
            lrck_prev_d = lrck_s;
        end

        if (!enable) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
            shift_d    = '0;
            have_l_d   = 1'b0;
            locked_d   = 1'b0;
        end else if (bclk_rise) begin
            case (state_q)
                ST_IDLE: state_d = ST_ALIGN;
                ST_ALIGN: begin
                    if (lrck_edge && !lrck_s) begin
                        start_slot = 1'b1;
                        start_fmt  = fmt_sel;
                        fmt_d      = fmt_sel;
                    end
                end
                default: begin
                    // An edge inside SHIFT is a short slot: the zero-padded partial word is kept
                    if (lrck_edge) begin
                        store      = (state_q == ST_SHIFT);
                        start_slot = 1'b1;
                    end else if (slot_cnt_q == SLOT_W'(MAX_SLOT)) begin
                        err_set    = 1'b1;
                        state_d    = ST_ALIGN;
                        have_l_d   = 1'b0;
                        locked_d   = 1'b0;
                        bit_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                        if (state_q != ST_HOLD) begin
                            shift_d[bit_idx] = sdata_s;
                            bit_cnt_d        = bit_cnt_q + CNT_W'(1);
                            state_d          = ST_SHIFT;
                            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                store   = 1'b1;
                                word    = shift_d;
                                state_d = ST_HOLD;
                            end
                        end
                    end
                end
            endcase
        end

        // New slot: left-justified takes the current bit as MSB, I2S skips one BCLK
        if (start_slot) begin
            ch_d       = lrck_s;
            slot_cnt_d = SLOT_W'(1);
            bit_cnt_d  = '0;
            shift_d    = '0;
            case (start_fmt)
                FMT_LJ: begin
                    shift_d[DATA_W-1] = sdata_s;
                    bit_cnt_d         = CNT_W'(1);
                    state_d           = ST_SHIFT;
                end
                FMT_I2S: state_d = ST_DELAY;
            endcase
        end

        if (store) begin
            if (!ch_q) begin
                l_hold_d = word;
                have_l_d = 1'b1;
            end else if (have_l_q) begin
                out_valid_d = 1'b1;
                out_l_d     = l_hold_q;
                out_r_d     = word;
                have_l_d    = 1'b0;
                locked_d    = 1'b1;
            end else begin
                err_set  = 1'b1;
                locked_d = 1'b0;
            end
        end

        frame_err_d = (frame_err_q & ~clear_err) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fmt_q       <= FMT_I2S;
            lrck_prev_q <= 1'b0;
            ch_q        <= 1'b0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            shift_q     <= '0;
            l_hold_q    <= '0;
            have_l_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fmt_q       <= fmt_d;
            lrck_prev_q <= lrck_prev_d;
            ch_q        <= ch_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            shift_q     <= shift_d;
            l_hold_q    <= l_hold_d;
            have_l_q    <= have_l_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;

endmodule
